// File: rtl/pc8001_bus_pkg.sv
// Shared bus-side types and constants for the PC-8001 main-RAM arbitration slice.
package pc8001_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        GRANT,
        RELEASE
    } dma_state_t;

    localparam int          RAM_AW    = 17;
    localparam logic [16:0] VRAM_BASE = 17'h0F000;

endpackage

// File: rtl/crtc_dma_arbiter_busak_sync.sv
// busak_sync: STAGES-deep synchronizer for the Z80 BUSAK_n line, preset to the inactive (1) level.
module busak_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '1;
        end else begin
            chain[0] <= d;
            for (int unsigned i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/crtc_dma_arbiter.sv
// CRTC row-fetch DMA responder: BUSRQ_n/BUSAK_n handshake, main-RAM mux, minimum CPU window.
// Optional BUSAK wait timeout with sticky dma_err: define CRTC_DMA_TIMEOUT_EN.
module crtc_dma_arbiter
    import pc8001_bus_pkg::*;
#(
    parameter int MIN_CPU_CYC = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DATA_REG    = 0,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              crtc_busreq,
    output logic              crtc_busack,
    input  logic [RAM_AW-1:0] crtc_adr,
    output logic [7:0]        crtc_data,
    output logic              cpu_busrq_n,
    input  logic              cpu_busak_n,
    input  logic [RAM_AW-1:0] cpu_ram_adr,
    input  logic              cpu_ram_we,
    input  logic [7:0]        cpu_ram_wdata,
    output logic [RAM_AW-1:0] ram_adr,
    output logic              ram_we,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata,
    output logic              dma_active,
    output logic              dma_err
);

    localparam int GAP_W = $clog2(MIN_CPU_CYC + 1);

    dma_state_t       state;
    logic             ak_n;
    logic             busack_q;
    logic             busrq_n_q;
    logic             active_q;
    logic [GAP_W-1:0] gap_cnt;

`ifdef CRTC_DMA_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);
    logic [WAIT_W-1:0] wait_cnt;
    logic              err_q;
`endif

    busak_sync #(
        .STAGES(SYNC_STAGES)
    ) u_busak_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (cpu_busak_n),
        .q    (ak_n)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busack_q  <= 1'b0;
            busrq_n_q <= 1'b1;
            active_q  <= 1'b0;
            gap_cnt   <= GAP_W'(MIN_CPU_CYC);
`ifdef CRTC_DMA_TIMEOUT_EN
            wait_cnt  <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (gap_cnt == GAP_W'(MIN_CPU_CYC)) begin
                        if (crtc_busreq) begin
                            state     <= REQ;
                            busrq_n_q <= 1'b0;
                            active_q  <= 1'b1;
`ifdef CRTC_DMA_TIMEOUT_EN
                            wait_cnt  <= '0;
`endif
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                REQ: begin
                    if (!ak_n) begin
                        state    <= GRANT;
                        busack_q <= 1'b1;
                    end else if (!crtc_busreq) begin
                        state     <= RELEASE;
                        busrq_n_q <= 1'b1;
                    end
`ifdef CRTC_DMA_TIMEOUT_EN
                    // Abandon the request; retry only after a full CPU gap.
                    else if (wait_cnt == WAIT_W'(TIMEOUT_CYC - 1)) begin
                        state     <= IDLE;
                        busrq_n_q <= 1'b1;
                        active_q  <= 1'b0;
                        gap_cnt   <= '0;
                        err_q     <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                GRANT: begin
                    // BUSAK_n rising here is ignored: only the CRTC ends a grant.
                    if (!crtc_busreq) begin
                        state     <= RELEASE;
                        busack_q  <= 1'b0;
                        busrq_n_q <= 1'b1;
                    end
                end
                RELEASE: begin
                    if (ak_n) begin
                        state    <= IDLE;
                        active_q <= 1'b0;
                        gap_cnt  <= '0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    busack_q  <= 1'b0;
                    busrq_n_q <= 1'b1;
                    active_q  <= 1'b0;
                end
            endcase
        end
    end

    assign crtc_busack = busack_q;
    assign cpu_busrq_n = busrq_n_q;
    assign dma_active  = active_q;

`ifdef CRTC_DMA_TIMEOUT_EN
    assign dma_err = err_q;
`else
    assign dma_err = 1'b0;
`endif

    // The registered grant flag steers the mux so an async reset returns RAM to the CPU at once.
    always_comb begin
        ram_adr   = cpu_ram_adr;
        ram_we    = cpu_ram_we;
        ram_wdata = cpu_ram_wdata;
        if (busack_q) begin
            ram_adr = crtc_adr;
            ram_we  = 1'b0;
        end
    end

    if (DATA_REG != 0) begin : g_data_reg
        logic [7:0] data_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_q <= '0;
            end else if (busack_q) begin
                data_q <= ram_rdata;
            end
        end
        assign crtc_data = data_q;
    end else begin : g_data_comb
        assign crtc_data = ram_rdata;
    end

endmodule

// File: tb/tb_crtc_dma_arbiter.sv
// Directed bench for crtc_dma_arbiter: one unregistered-data and one registered-data instance.
`timescale 1ns/1ps
module tb_crtc_dma_arbiter;
    import pc8001_bus_pkg::*;

    localparam int MIN_CYC = 8;

    logic        clk;
    logic        rst_n;
    logic        crtc_busreq;
    logic [16:0] crtc_adr;
    logic        cpu_busak_n;
    logic [16:0] cpu_ram_adr;
    logic        cpu_ram_we;
    logic [7:0]  cpu_ram_wdata;
    logic [7:0]  ram_rdata;

    logic        busack0, busrq_n0, ram_we0, active0, err0;
    logic [7:0]  crtc_data0, ram_wdata0;
    logic [16:0] ram_adr0;
    logic        busack1, busrq_n1, ram_we1, active1, err1;
    logic [7:0]  crtc_data1, ram_wdata1;
    logic [16:0] ram_adr1;

    int unsigned n_cmp;
    int unsigned n_bad;
    int unsigned n;

    crtc_dma_arbiter #(
        .MIN_CPU_CYC(MIN_CYC),
        .SYNC_STAGES(2),
        .DATA_REG   (0),
        .TIMEOUT_CYC(16)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .crtc_busreq  (crtc_busreq),
        .crtc_busack  (busack0),
        .crtc_adr     (crtc_adr),
        .crtc_data    (crtc_data0),
        .cpu_busrq_n  (busrq_n0),
        .cpu_busak_n  (cpu_busak_n),
        .cpu_ram_adr  (cpu_ram_adr),
        .cpu_ram_we   (cpu_ram_we),
        .cpu_ram_wdata(cpu_ram_wdata),
        .ram_adr      (ram_adr0),
        .ram_we       (ram_we0),
        .ram_wdata    (ram_wdata0),
        .ram_rdata    (ram_rdata),
        .dma_active   (active0),
        .dma_err      (err0)
    );

    crtc_dma_arbiter #(
        .MIN_CPU_CYC(MIN_CYC),
        .SYNC_STAGES(2),
        .DATA_REG   (1),
        .TIMEOUT_CYC(16)
    ) u_dut_reg (
        .clk          (clk),
        .rst_n        (rst_n),
        .crtc_busreq  (crtc_busreq),
        .crtc_busack  (busack1),
        .crtc_adr     (crtc_adr),
        .crtc_data    (crtc_data1),
        .cpu_busrq_n  (busrq_n1),
        .cpu_busak_n  (cpu_busak_n),
        .cpu_ram_adr  (cpu_ram_adr),
        .cpu_ram_we   (cpu_ram_we),
        .cpu_ram_wdata(cpu_ram_wdata),
        .ram_adr      (ram_adr1),
        .ram_we       (ram_we1),
        .ram_wdata    (ram_wdata1),
        .ram_rdata    (ram_rdata),
        .dma_active   (active1),
        .dma_err      (err1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        crtc_busreq = 1'b0;
        crtc_adr = '0;
        cpu_busak_n = 1'b1;
        cpu_ram_adr = 17'h12345;
        cpu_ram_we = 1'b0;
        cpu_ram_wdata = 8'h00;
        ram_rdata = 8'h00;

        tick();
        tick();
        check("rst_busack", busack0, 1'b0);
        check("rst_busrq_n", busrq_n0, 1'b1);
        check("rst_active", active0, 1'b0);
        check("rst_err", err0, 1'b0);
        check("rst_data_reg", crtc_data1, 8'h00);
        check("rst_ram_adr", ram_adr0, 17'h12345);

        // Gap is already satisfied out of reset: request goes out on the next edge.
        rst_n = 1'b1;
        crtc_busreq = 1'b1;
        n = 0;
        while (busrq_n0 && n < 10) begin tick(); n++; end
        check("req_latency", n, 1);
        check("req_active", active0, 1'b1);
        tick(); tick(); tick();
        cpu_busak_n = 1'b0;
        tick();
        tick();
        check("busack_before_ak", busack0, 1'b0);
        tick();
        check("busack_at_ak_plus1", busack0, 1'b1);
        check("busack_reg_inst", busack1, 1'b1);

        crtc_adr = VRAM_BASE + 17'h00300;
        #1;
        check("grant_ram_adr", ram_adr0, 17'h0F300);
        ram_rdata = 8'hA5;
        #1;
        check("data_comb", crtc_data0, 8'hA5);
        check("data_reg_before", crtc_data1, 8'h00);
        tick();
        check("data_reg_after", crtc_data1, 8'hA5);

        cpu_ram_adr = 17'h00100;
        cpu_ram_wdata = 8'h3C;
        cpu_ram_we = 1'b1;
        #1;
        check("grant_we_blocked", ram_we0, 1'b0);
        check("grant_adr_crtc", ram_adr0, 17'h0F300);

        crtc_busreq = 1'b0;
        tick();
        check("rel_busack", busack0, 1'b0);
        check("rel_busrq_n", busrq_n0, 1'b1);
        check("rel_active", active0, 1'b1);
        check("rel_ram_we", ram_we0, 1'b1);
        check("rel_ram_adr", ram_adr0, 17'h00100);
        check("rel_ram_wdata", ram_wdata0, 8'h3C);
        cpu_ram_we = 1'b0;

        tick();
        crtc_busreq = 1'b1;
        cpu_busak_n = 1'b1;
        n = 0;
        while (active0 && n < 10) begin tick(); n++; end
        check("idle_after_ak", active0, 1'b0);
        n = 0;
        while (busrq_n0 && n < 30) begin tick(); n++; end
        check("gap_len_ok", (n >= MIN_CYC && n <= MIN_CYC + 1), 1'b1);

`ifndef CRTC_DMA_TIMEOUT_EN
        for (int i = 0; i < 20; i++) tick();
        check("req_holds", busrq_n0, 1'b0);
        check("req_no_err", err0, 1'b0);
        check("req_no_busack", busack0, 1'b0);
`endif
        cpu_busak_n = 1'b0;
        cpu_ram_adr = 17'h1ABCD;
        n = 0;
        while (!busack0 && n < 10) begin tick(); n++; end
        check("regrant", busack0, 1'b1);
        check("regrant_adr", ram_adr0, 17'h0F300);

        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busack", busack0, 1'b0);
        check("arst_busrq_n", busrq_n0, 1'b1);
        check("arst_active", active0, 1'b0);
        check("arst_ram_adr", ram_adr0, 17'h1ABCD);
        check("arst_data_reg", crtc_data1, 8'h00);
        crtc_busreq = 1'b0;
        cpu_busak_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (busrq_n0 && !busack0) n++;
        end
        check("post_rst_quiet", n, 5);

`ifdef CRTC_DMA_TIMEOUT_EN
        crtc_busreq = 1'b1;
        n = 0;
        while (busrq_n0 && n < 10) begin tick(); n++; end
        check("to_req", busrq_n0, 1'b0);
        n = 0;
        while (!err0 && n < 40) begin tick(); n++; end
        check("to_cycles", n, 16);
        check("to_err", err0, 1'b1);
        check("to_busrq_n", busrq_n0, 1'b1);
        n = 0;
        while (busrq_n0 && n < 30) begin tick(); n++; end
        check("to_retry_gap", (n >= MIN_CYC && n <= MIN_CYC + 1), 1'b1);
        check("to_err_sticky", err0, 1'b1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
